// File: rtl/wb_lsu_master.sv
// Load/store unit bridging an RV32I core request to a Wishbone pipelined master cycle.
// Optional LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete immediately with o_bus_err.
//
// state | meaning
// IDLE  | waiting for i_valid, bus idle
// REQ   | cyc/stb asserted, waiting for slave to accept (stall low)
// WAIT  | strobe accepted, cyc held, waiting for ack
// DONE  | one-cycle o_done pulse with result/error
module wb_lsu_master #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_bus_err,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [9:0]  tmo_cnt;
   logic [2:0]  f3_q;
   logic [1:0]  lane_q;
   logic        trap;
   logic        ack_ok;

   // funct3[1:0] selects size (00 B, 01 H, 1x W); funct3[2] selects zero-extension.
   function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   lane_sel = 4'b0001 << a;
         2'b01:   lane_sel = a[1] ? 4'b1100 : 4'b0011;
         default: lane_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   store_data = {4{d[7:0]}};
         2'b01:   store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

   function automatic logic [31:0] load_data(input logic [2:0] f3, input logic [1:0] lane,
                                             input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> {lane, 3'b000});
      h = lane[1] ? d[31:16] : d[15:0];
      case (f3)
         3'b000:  load_data = {{24{b[7]}}, b};
         3'b100:  load_data = {24'd0, b};
         3'b001:  load_data = {{16{h[15]}}, h};
         3'b101:  load_data = {16'd0, h};
         default: load_data = d;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   always_comb begin
      case (i_funct3[1:0])
         2'b00:   trap = 1'b0;
         2'b01:   trap = i_addr[0];
         default: trap = (i_addr[1:0] != 2'b00);
      endcase
   end
`else
   assign trap = 1'b0;
`endif

   // An ack only counts once the strobe has been (or is being) accepted.
   assign ack_ok = i_wb_ack && ((state == WAIT) || ((state == REQ) && !i_wb_stall));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         tmo_cnt   <= '0;
         f3_q      <= '0;
         lane_q    <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_rdata   <= '0;
         o_bus_err <= 1'b0;
         o_wb_cyc  <= 1'b0;
         o_wb_stb  <= 1'b0;
         o_wb_we   <= 1'b0;
         o_wb_addr <= '0;
         o_wb_data <= '0;
         o_wb_sel  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  f3_q   <= i_funct3;
                  lane_q <= i_addr[1:0];
                  o_busy <= 1'b1;
                  if (trap) begin
                     state     <= DONE;
                     o_done    <= 1'b1;
                     o_bus_err <= 1'b1;
                     o_rdata   <= '0;
                  end else begin
                     state     <= REQ;
                     tmo_cnt   <= '0;
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_we   <= i_we;
                     o_wb_addr <= {i_addr[31:2], 2'b00};
                     o_wb_sel  <= lane_sel(i_funct3, i_addr[1:0]);
                     o_wb_data <= i_we ? store_data(i_funct3, i_wdata) : 32'd0;
                  end
               end
            end
            REQ, WAIT: begin
               if (ack_ok) begin
                  state     <= DONE;
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  o_done    <= 1'b1;
                  o_bus_err <= 1'b0;
                  o_rdata   <= o_wb_we ? 32'd0 : load_data(f3_q, lane_q, i_wb_data);
               end else if (tmo_cnt == TMO_LAST) begin
                  state     <= DONE;
                  o_wb_cyc  <= 1'b0;
                  o_wb_stb  <= 1'b0;
                  o_done    <= 1'b1;
                  o_bus_err <= 1'b1;
                  o_rdata   <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 10'd1;
                  if ((state == REQ) && !i_wb_stall) begin
                     o_wb_stb <= 1'b0;
                     state    <= WAIT;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               o_busy    <= 1'b0;
               o_done    <= 1'b0;
               o_bus_err <= 1'b0;
               o_rdata   <= '0;
               o_wb_we   <= 1'b0;
               o_wb_addr <= '0;
               o_wb_data <= '0;
               o_wb_sel  <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Randomized bench for wb_lsu_master against a cycle-level reference of the request timeline.
module tb_wb_lsu_master;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_valid = 1'b0, i_we = 1'b0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_addr = '0, i_wdata = '0;
   logic        o_busy, o_done, o_bus_err, o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0] o_rdata, o_wb_addr, o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0;
   logic [31:0] i_wb_data = '0;

   int n_cmp = 0;
   int n_bad = 0;

   wb_lsu_master #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_we(i_we), .i_funct3(i_funct3),
      .i_addr(i_addr), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata),
      .o_bus_err(o_bus_err), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack),
      .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic logic [31:0] exp_sel(input logic [2:0] f3, input logic [31:0] a);
      int sz = size_of(f3);
      if (sz == 1) return 32'(1) << (a % 4);
      if (sz == 2) return 32'(3) << (2 * ((a / 2) % 2));
      return 32'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      int sz = size_of(f3);
      if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] bus);
      int sz = size_of(f3);
      logic [31:0] v;
      if (sz == 1) begin
         v = (bus >> (8 * (a % 4))) & 32'hFF;
         if (f3 == 3'b000 && v >= 32'd128) v = v | 32'hFFFF_FF00;
         return v;
      end
      if (sz == 2) begin
         v = (bus >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (f3 == 3'b001 && v >= 32'd32768) v = v | 32'hFFFF_0000;
         return v;
      end
      return bus;
   endfunction

   // S = stall cycles on the strobe, L = ack delay after acceptance (0 = same cycle).
   task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] bus,
                          input int s, input int l, input bit noack);
      int  a, dc;
      bit  mis, tmo, err, stb_e;
      mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis = (size_of(f3) == 2 && addr[0]) || (size_of(f3) == 4 && addr[1:0] != 2'b00);
`endif
      a   = s + 1 + l;
      tmo = !mis && (noack || (a - 1) >= TMO);
      dc  = mis ? 1 : (tmo ? TMO + 1 : a + 1);
      err = mis || tmo;
      for (int c = 0; c <= dc + 1; c++) begin
         @(negedge clk);
         if (c >= 1) begin
            chk("busy", 32'(o_busy), 32'(c <= dc));
            chk("done", 32'(o_done), 32'(c == dc));
            chk("cyc", 32'(o_wb_cyc), 32'(!mis && c < dc));
            stb_e = !mis && c <= s + 1 && c < dc;
            chk("stb", 32'(o_wb_stb), 32'(stb_e));
            if (stb_e) begin
               chk("wb_addr", o_wb_addr, addr & 32'hFFFF_FFFC);
               chk("wb_sel", 32'(o_wb_sel), exp_sel(f3, addr));
               chk("wb_data", o_wb_data, we ? exp_wdata(f3, wdata) : 32'd0);
               chk("wb_we", 32'(o_wb_we), 32'(we));
            end
            if (c == dc) begin
               chk("bus_err", 32'(o_bus_err), 32'(err));
               if (!we || err) chk("rdata", o_rdata, err ? 32'd0 : exp_rdata(f3, addr, bus));
            end
         end
         i_valid    = (c == 0) || (c == dc && $urandom_range(0, 1) == 1);
         i_we       = (c == 0) ? we    : 1'($urandom);
         i_funct3   = (c == 0) ? f3    : 3'($urandom);
         i_addr     = (c == 0) ? addr  : $urandom;
         i_wdata    = (c == 0) ? wdata : $urandom;
         i_wb_stall = (c >= 1 && c <= s) || (c > s + 1 && $urandom_range(0, 1) == 1);
         i_wb_ack   = (!noack && c == a) || ((c == 0 || c >= dc) && $urandom_range(0, 1) == 1);
         i_wb_data  = (c == a) ? bus : $urandom;
      end
      i_valid  = 1'b0;
      i_wb_ack = 1'b0;
   endtask

   task automatic reset_in_wait();
      @(negedge clk);
      i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h300;
      i_wb_stall = 1'b0; i_wb_ack = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre_cyc", 32'(o_wb_cyc), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cyc", 32'(o_wb_cyc), 32'd0);
      chk("rst_stb", 32'(o_wb_stb), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_done", 32'(o_done), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         i_wb_ack = 1'($urandom);
         @(negedge clk);
         chk("post_rst_done", 32'(o_done), 32'd0);
         chk("post_rst_busy", 32'(o_busy), 32'd0);
      end
      i_wb_ack = 1'b0;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1;
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_done", 32'(o_done), 32'd0);
      chk("reset_cyc", 32'(o_wb_cyc), 32'd0);
      chk("reset_stb", 32'(o_wb_stb), 32'd0);
      chk("reset_rdata", o_rdata, 32'd0);
      chk("reset_err", 32'(o_bus_err), 32'd0);
      chk("reset_sel", 32'(o_wb_sel), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_txn(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0, 1, 1'b0);
      run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0);
      run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0);
      run_txn(1'b0, 3'b101, 32'h202, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0);
      run_txn(1'b0, 3'b001, 32'h202, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0);
      run_txn(1'b1, 3'b000, 32'h11, 32'h0000_00A5, 32'h0, 0, 1, 1'b0);
      run_txn(1'b1, 3'b001, 32'h22, 32'h1234_5678, 32'h0, 0, 0, 1'b0);
      run_txn(1'b0, 3'b010, 32'h40, 32'h0, 32'h1357_9BDF, 3, 0, 1'b0);
      run_txn(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 0, 0, 1'b1);
      run_txn(1'b1, 3'b010, 32'h84, 32'h5555_AAAA, 32'h0, 6, 0, 1'b1);
      run_txn(1'b0, 3'b011, 32'h90, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0);
      run_txn(1'b0, 3'b110, 32'h94, 32'h0, 32'h8765_4321, 0, 2, 1'b0);
      run_txn(1'b0, 3'b111, 32'h98, 32'h0, 32'hFFFF_0001, 0, 1, 1'b0);
      run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'hA5A5_5A5A, 0, 1, 1'b0);
      reset_in_wait();
      run_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BAD_CAFE, 0, 1, 1'b0);

      for (int k = 0; k < 200; k++) begin
         run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/wb_lsu_master.md
WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: bus cycles waited for ack, counted from first stb, before abort with error; range 1..1023.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_valid  in  1  core memory request strobe; sampled only in IDLE.
REQ-005 i_we  in  1  1=store, 0=load.
REQ-006 i_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 i_addr  in  32  byte address; i_wdata  in  32  store data (rs2).
REQ-008 o_busy  out  1  high in every state except IDLE; core stalls on it.
REQ-009 o_done  out  1  one-cycle completion pulse; o_rdata  out  32  aligned, extended load result, valid with o_done.
REQ-010 o_bus_err  out  1  valid with o_done; 1=timeout (or misalignment, see Configuration).
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each; o_wb_addr  out  32; o_wb_data  out  32; o_wb_sel  out  4  Wishbone pipelined master outputs, all registered.
REQ-012 i_wb_ack, i_wb_stall  in  1 each; i_wb_data  in  32  Wishbone slave responses.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-014 IDLE & i_valid: latch request; next cycle REQ with cyc=stb=1, we=i_we, addr={i_addr[31:2],2'b00}.
REQ-015 Store sel: B 4'b0001<<addr[1:0], data byte replicated x4; H 4'b0011<<{addr[1],1'b0}, halfword replicated x2; W 4'b1111, data unchanged; loads use same sel, data 0.
REQ-016 REQ & !i_wb_stall: stb deasserts next cycle; next state WAIT, or DONE if i_wb_ack same cycle.
REQ-017 REQ & i_wb_stall: hold stb, addr, data, sel unchanged.
REQ-018 WAIT & i_wb_ack: capture i_wb_data, cyc=0 next cycle, enter DONE.
REQ-019 Ack outside REQ/WAIT SHALL be ignored.
REQ-020 Timeout counter clears on REQ entry, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES without ack: cyc=stb=0, DONE with o_bus_err=1, o_rdata=0.
REQ-021 DONE: o_done=1 exactly one cycle, then IDLE; i_valid in DONE ignored.
REQ-022 Load extraction: lane = addr[1:0] (B) or addr[1] (H); B/H sign-extend bit 7/15; BU/HU zero-extend; W unchanged.
REQ-023 Minimum latency, zero-wait slave (ack cycle after stb accepted): i_valid cycle 0, stb cycle 1, ack cycle 2, o_done cycle 3.
REQ-024 Undefined funct3 (011,110,111) SHALL behave as W.

Reset
REQ-025 On i_rst_n low, immediately: state IDLE, all outputs 0, counter 0, latched request cleared.
REQ-026 Reset mid-cycle SHALL drop cyc/stb asynchronously; no o_done is produced for the aborted request.

Configuration
REQ-027 Macro LSU_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=0 issues no bus cycle; IDLE->DONE directly, o_bus_err=1, o_rdata=0, done at cycle 1.
REQ-028 Macro undefined: low address bits ignored for alignment; H uses addr[1], W uses word addr[31:2]; no error raised.

Verification
REQ-029 SW addr 0x104 data 0xDEADBEEF, zero-wait slave -> cyc/stb cycle 1, sel 1111, addr 0x104, o_done cycle 3, o_bus_err 0.
REQ-030 LB addr 0x203, slave data 0x80AABBCC -> o_rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x202 -> 0x000080AA.
REQ-031 SB addr 0x11 data 0x000000A5 -> sel 0010, o_wb_data 0xA5A5A5A5, addr 0x10.
REQ-032 Slave stall 3 cycles then ack -> stb held 4 cycles with stable addr/data; single o_done.
REQ-033 TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 cycles, o_done with o_bus_err 1, o_rdata 0.
REQ-034 Reset asserted in WAIT -> cyc 0 same cycle, no o_done; with LSU_MISALIGN_TRAP_EN, LW addr 0x102 -> no cyc, o_done cycle 1, o_bus_err 1.
